// File: rtl/qspi_target_responder_pkg.sv
// Shared types and command codes for the QSPI target responder.
// Pure declarations: no latency, no flow control.
package qspi_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

endpackage

// File: rtl/qspi_target_responder_if.sv
// Link pins plus the write-commit and status side-band of the QSPI target responder.
// Wiring only; the link has no backpressure, the initiator owns SCK pacing.
interface qspi_target_responder_if #(
  parameter int ADDR_W = 4
);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              err;
  logic              err_clr;

  modport slave (
    input  sck, cs_n, mosi, err_clr,
    output miso, miso_oe, wr_valid, wr_addr, wr_data, busy, err
  );

  modport master (
    output sck, cs_n, mosi, err_clr,
    input  miso, miso_oe, wr_valid, wr_addr, wr_data, busy, err
  );

endinterface

// File: rtl/qspi_target_responder_pin_sync.sv
// Two-flop synchronizer on W async pins; bit 0 gets a third flop for rise/fall detect.
// Latency: 2 cycles to dout, edges valid the same cycle dout changes; no backpressure.
module qspi_pin_sync #(
  parameter int           W       = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] meta;
  logic         edge_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta   <= RST_VAL;
      dout   <= RST_VAL;
      edge_d <= RST_VAL[0];
    end else begin
      meta   <= din;
      dout   <= meta;
      edge_d <= dout[0];
    end
  end

  assign rise = dout[0] & ~edge_d;
  assign fall = ~dout[0] & edge_d;

endmodule

// File: rtl/qspi_target_responder.sv
// SPI mode-0 target serving byte reads/writes to an internal register file over the link.
// Pin-to-internal 3 cycles; write commit 1 cycle after 8th rise; no backpressure.
module qspi_target_responder
  import qspi_target_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  qspi_target_responder_if.slave  io
);

  logic        sck_rise, sck_fall;
  logic        cs_s, mosi_s;
  logic        unused_sck_s;

  state_t      state, state_nx;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        cmd_ok;
  logic        is_rd;
  logic        armed;
  logic        load_pend;
  logic [7:0]  tx_shift;
  logic [ADDR_W-1:0] addr;
  logic [7:0]  mem [DEPTH];
  logic        err_q;
  logic        wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]  wr_data_q;

  // CS_n syncs to "asserted" on reset so a burst already in flight never looks like a fresh fall.
  qspi_pin_sync #(.W(3), .RST_VAL(3'b000)) u_pin_sync (
    .clock (clock),
    .reset (reset),
    .din   ({io.mosi, io.cs_n, io.sck}),
    .dout  ({mosi_s, cs_s, unused_sck_s}),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = sck_rise & (bit_cnt == 3'd7) & ~cs_s;
  assign cmd_ok    = (rx_byte == CMD_WRITE) || (rx_byte == CMD_READ);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state != ST_IDLE && cs_s) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (!cs_s && armed) state_nx = ST_CMD;
        ST_CMD:   if (byte_done) state_nx = cmd_ok ? ST_ADDR : ST_IGNORE;
        ST_ADDR:  if (byte_done) state_nx = is_rd ? ST_RD_DATA : ST_WR_DATA;
        default:  state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= '0;
      rx_shift   <= '0;
      is_rd      <= 1'b0;
      armed      <= 1'b0;
      load_pend  <= 1'b0;
      tx_shift   <= '0;
      addr       <= '0;
      err_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (cs_s) armed <= 1'b1;

      // Partial bytes are dropped whenever the link is idle or deselected.
      if (state == ST_IDLE || cs_s) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
      end

      if (state == ST_IDLE) begin
        tx_shift  <= '0;
        load_pend <= 1'b0;
      end

      if (byte_done) begin
        case (state)
          ST_CMD:  is_rd <= (rx_byte == CMD_READ);
          ST_ADDR: begin
            addr      <= rx_byte[ADDR_W-1:0];
            load_pend <= 1'b1;
          end
          ST_WR_DATA: begin
            mem[addr]  <= rx_byte;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= addr;
            wr_data_q  <= rx_byte;
            addr       <= addr + ADDR_W'(1);
          end
          ST_RD_DATA: load_pend <= 1'b1;
          default: ;
        endcase
      end

      // First fall after a byte boundary fetches the next byte; the rest shift it out.
      if (state == ST_RD_DATA && sck_fall && !cs_s) begin
        if (load_pend) begin
          tx_shift  <= mem[addr];
          addr      <= addr + ADDR_W'(1);
          load_pend <= 1'b0;
        end else begin
          tx_shift  <= {tx_shift[6:0], 1'b0};
        end
      end

      if (state == ST_CMD && byte_done && !cmd_ok) err_q <= 1'b1;
      else if (io.err_clr)                         err_q <= 1'b0;
    end
  end

  assign io.miso_oe  = (state == ST_RD_DATA) & ~cs_s;
  assign io.miso     = io.miso_oe & tx_shift[7];
  assign io.busy     = ~cs_s & armed;
  assign io.err      = err_q;
  assign io.wr_valid = wr_valid_q;
  assign io.wr_addr  = wr_addr_q;
  assign io.wr_data  = wr_data_q;

endmodule

// File: tb/tb_qspi_target_responder.sv
// Bench for qspi_target_responder: table-driven link transactions plus abort/error/reset sequences.
module tb_qspi_target_responder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int HALF  = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  qspi_target_responder_if #(.ADDR_W(AW)) io ();

  qspi_target_responder #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    logic          wr;
    logic [7:0]    addr;
    logic [7:0]    d0, d1;
    logic [AW-1:0] ea0, ea1;
    logic [7:0]    e0, e1;
  } vec_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  vec_t       vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Every commit pulse must match the next expected write, one pop per high cycle.
  always @(negedge clock) begin
    wr_t e;
    if (reset && io.wr_valid === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", io.wr_addr, io.wr_data);
      end else begin
        e = wq.pop_front();
        check("wr_addr", io.wr_addr, e.a);
        check("wr_data", io.wr_data, e.d);
      end
    end
  end

  task automatic xfer(input logic [7:0] tx, input int nbits, input logic exp_oe, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      io.sck  = 1'b0;
      io.mosi = tx[7-i];
      tick(HALF);
      rx[7-i] = io.miso;
      check("miso_oe", io.miso_oe, exp_oe);
      io.sck = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic cs_begin();
    io.cs_n = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_end();
    io.sck = 1'b0;
    tick(HALF);
    io.cs_n = 1'b1;
    tick(8);
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] rx;
    cs_begin();
    check("busy_active", io.busy, 1'b1);
    xfer(v.wr ? 8'h02 : 8'h03, 8, 1'b0, rx);
    xfer(v.addr, 8, 1'b0, rx);
    if (v.wr) begin
      wq.push_back({v.ea0, v.e0});
      wq.push_back({v.ea1, v.e1});
      xfer(v.d0, 8, 1'b0, rx);
      xfer(v.d1, 8, 1'b0, rx);
    end else begin
      rq.push_back(v.e0);
      rq.push_back(v.e1);
      xfer(8'h00, 8, 1'b1, rx);
      check("rd_byte0", rx, rq.pop_front());
      xfer(8'h00, 8, 1'b1, rx);
      check("rd_byte1", rx, rq.pop_front());
    end
    cs_end();
    check("busy_idle", io.busy, 1'b0);
    check("oe_idle", io.miso_oe, 1'b0);
    check("miso_idle", io.miso, 1'b0);
    check("wr_drain", wq.size(), 0);
    check("err_clean", io.err, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     io.miso,     1'b0);
    check({tag, "_miso_oe"},  io.miso_oe,  1'b0);
    check({tag, "_wr_valid"}, io.wr_valid, 1'b0);
    check({tag, "_wr_addr"},  io.wr_addr,  '0);
    check({tag, "_wr_data"},  io.wr_data,  8'h00);
    check({tag, "_busy"},     io.busy,     1'b0);
    check({tag, "_err"},      io.err,      1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    vec_t v;

    //          wr    addr   d0     d1     ea0   ea1   e0     e1
    vt[0] = '{1'b1, 8'h03, 8'hA5, 8'h5A, 4'h3, 4'h4, 8'hA5, 8'h5A};
    vt[1] = '{1'b0, 8'h03, 8'h00, 8'h00, 4'h0, 4'h0, 8'hA5, 8'h5A};
    vt[2] = '{1'b1, 8'h0F, 8'h11, 8'h22, 4'hF, 4'h0, 8'h11, 8'h22};
    vt[3] = '{1'b0, 8'h0F, 8'h00, 8'h00, 4'h0, 4'h0, 8'h11, 8'h22};
    vt[4] = '{1'b1, 8'h37, 8'hC3, 8'h3C, 4'h7, 4'h8, 8'hC3, 8'h3C};
    vt[5] = '{1'b0, 8'h07, 8'h00, 8'h00, 4'h0, 4'h0, 8'hC3, 8'h3C};
    vt[6] = '{1'b0, 8'h05, 8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00};

    io.sck     = 1'b0;
    io.cs_n    = 1'b1;
    io.mosi    = 1'b0;
    io.err_clr = 1'b0;
    reset      = 1'b0;
    tick(4);
    check_reset_outputs("rst");
    reset = 1'b1;
    tick(6);
    check_reset_outputs("post_rst");

    for (int i = 0; i < 7; i++) run_txn(vt[i]);

    // Unknown command: everything after it is ignored and the error sticks.
    cs_begin();
    xfer(8'h55, 8, 1'b0, rx);
    xfer(8'hA5, 8, 1'b0, rx);
    xfer(8'h5A, 8, 1'b0, rx);
    cs_end();
    check("err_set", io.err, 1'b1);
    io.err_clr = 1'b1;
    tick(1);
    io.err_clr = 1'b0;
    tick(1);
    check("err_cleared", io.err, 1'b0);

    // Abort five bits into a write data byte: nothing commits.
    cs_begin();
    xfer(8'h02, 8, 1'b0, rx);
    xfer(8'h09, 8, 1'b0, rx);
    xfer(8'hEE, 5, 1'b0, rx);
    cs_end();
    check("abort_busy", io.busy, 1'b0);
    check("abort_no_wr", wq.size(), 0);
    v = '{1'b1, 8'h0A, 8'h77, 8'h88, 4'hA, 4'hB, 8'h77, 8'h88};
    run_txn(v);
    v = '{1'b0, 8'h09, 8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 8'h77};
    run_txn(v);

    // Leave err set, then reset in the middle of a read data byte.
    cs_begin();
    xfer(8'hFF, 8, 1'b0, rx);
    cs_end();
    check("err_set2", io.err, 1'b1);
    cs_begin();
    xfer(8'h03, 8, 1'b0, rx);
    xfer(8'h03, 8, 1'b0, rx);
    xfer(8'h00, 4, 1'b1, rx);
    reset = 1'b0;
    tick(3);
    check_reset_outputs("mid_rst");
    reset = 1'b1;
    tick(4);
    xfer(8'h02, 8, 1'b0, rx);
    xfer(8'h01, 8, 1'b0, rx);
    cs_end();
    check("ignored_burst_no_wr", wq.size(), 0);
    v = '{1'b0, 8'h03, 8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00};
    run_txn(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
